// File: rtl/kernel_cc_start_fifo_bcast_if.sv
// Producer/consumer handshake bundle for the broadcast start FIFO.
// The master side is the kernel processes; the slave side is the FIFO.
interface kernel_cc_start_fifo_bcast_if #(
  parameter int DATA_WIDTH = 1,
  parameter int NUM_RD     = 2
);
  logic                  write_ce;
  logic                  write;
  logic [DATA_WIDTH-1:0] din;
  logic                  full_n;
  logic                  read_ce;
  logic [NUM_RD-1:0]     read;
  logic [NUM_RD-1:0]     empty_n;
  logic [DATA_WIDTH-1:0] dout;

  modport master (
    output write_ce, write, din, read_ce, read,
    input  full_n, empty_n, dout
  );

  modport slave (
    input  write_ce, write, din, read_ce, read,
    output full_n, empty_n, dout
  );
endinterface

// File: rtl/kernel_cc_start_fifo_bcast.sv
// Shift-register token FIFO with broadcast read: the head retires only after every
// consumer has taken it. Adds occupancy, almost flags and sticky error flags.
module kernel_cc_start_fifo_bcast #(
  parameter int DATA_WIDTH = 1,
  parameter int DEPTH      = 4,
  parameter int ADDR_WIDTH = 2,
  parameter int NUM_RD     = 2,
  parameter int AF_LEVEL   = 3,
  parameter int AE_LEVEL   = 1
) (
  input  logic                    clk,
  input  logic                    reset,
  kernel_cc_start_fifo_bcast_if.slave bus,
  output logic [ADDR_WIDTH:0]     usedw,
  output logic                    almost_full,
  output logic                    almost_empty,
  output logic                    wr_overflow,
  output logic [NUM_RD-1:0]       rd_underflow
);

  localparam int              CW      = ADDR_WIDTH + 1;
  localparam logic [CW-1:0]   DEPTH_C = CW'(DEPTH);
  localparam logic [CW-1:0]   AF_C    = CW'(AF_LEVEL);
  localparam logic [CW-1:0]   AE_C    = CW'(AE_LEVEL);

  logic [DATA_WIDTH-1:0] srl [DEPTH];
  logic [CW-1:0]         count;
  logic [CW-1:0]         count_next;
  logic                  full_n;
  logic                  nonempty;
  logic                  push;
  logic                  pop;
  logic [NUM_RD-1:0]     taken;
  logic [NUM_RD-1:0]     empty_n;
  logic [NUM_RD-1:0]     rd_req;
  logic [NUM_RD-1:0]     rd_acc;
  logic [ADDR_WIDTH-1:0] head_idx;

  // NOTE: every always_comb output gets a value on every path, so no latch is inferred.
  always_comb begin
    nonempty   = (count != '0);
    empty_n    = {NUM_RD{nonempty}} & ~taken;
    rd_req     = bus.read & {NUM_RD{bus.read_ce}};
    rd_acc     = rd_req & empty_n;
    push       = bus.write & bus.write_ce & full_n;
    // Retire only when each consumer has either already read the head or reads it now.
    pop        = nonempty & (&(taken | rd_acc));
    count_next = count + CW'(push) - CW'(pop);
    head_idx   = nonempty ? ADDR_WIDTH'(count - 1'b1) : '0;
  end

  assign bus.full_n  = full_n;
  assign bus.empty_n = empty_n;
  assign bus.dout    = srl[head_idx];
  assign usedw       = count;

  // NOTE: the data shift register carries no reset; count/taken alone define which entries are valid.
  always_ff @(posedge clk) begin
    if (push) begin
      srl[0] <= bus.din;
      for (int i = 1; i < DEPTH; i++) srl[i] <= srl[i-1];
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      count        <= '0;
      full_n       <= 1'b1;
      taken        <= '0;
      almost_full  <= 1'b0;
      almost_empty <= 1'b1;
      wr_overflow  <= 1'b0;
      rd_underflow <= '0;
    end else begin
      count        <= count_next;
      full_n       <= (count_next != DEPTH_C);
      almost_full  <= (count_next >= AF_C);
      almost_empty <= (count_next <= AE_C);
      taken        <= pop ? '0 : (taken | rd_acc);
      wr_overflow  <= wr_overflow | (bus.write & bus.write_ce & ~full_n);
      rd_underflow <= rd_underflow | (rd_req & ~empty_n);
    end
  end

endmodule

// File: tb/tb_kernel_cc_start_fifo_bcast.sv
// Directed and random checks of the broadcast start FIFO against a queue-based model.
module tb_kernel_cc_start_fifo_bcast;

  localparam int DW = 4, DEPTH = 4, AW = 2, NR = 2, AF = 3, AE = 1;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  kernel_cc_start_fifo_bcast_if #(.DATA_WIDTH(DW), .NUM_RD(NR)) bus ();

  logic [AW:0]   usedw;
  logic          almost_full, almost_empty, wr_overflow;
  logic [NR-1:0] rd_underflow;

  kernel_cc_start_fifo_bcast #(
    .DATA_WIDTH(DW), .DEPTH(DEPTH), .ADDR_WIDTH(AW),
    .NUM_RD(NR), .AF_LEVEL(AF), .AE_LEVEL(AE)
  ) dut (
    .clk(clk),
    .reset(reset),
    .bus(bus),
    .usedw(usedw),
    .almost_full(almost_full),
    .almost_empty(almost_empty),
    .wr_overflow(wr_overflow),
    .rd_underflow(rd_underflow)
  );

  // Reference model: token queue plus per-consumer "already read head" bits.
  logic [DW-1:0] q[$];
  logic [NR-1:0] m_taken;
  logic [NR-1:0] m_under;
  logic          m_over;

  int n_checks = 0;
  int n_pass   = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    assert (got === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, got, exp);
    end
  endtask

  task automatic drive(input logic rst, input logic w, input logic wce, input logic [DW-1:0] d,
                       input logic rce, input logic [NR-1:0] rd);
    reset        = rst;
    bus.write    = w;
    bus.write_ce = wce;
    bus.din      = d;
    bus.read_ce  = rce;
    bus.read     = rd;
  endtask

  task automatic model_step();
    logic          full, all_done, do_push;
    logic [NR-1:0] acc;
    if (reset) begin
      q.delete();
      m_taken = '0;
      m_under = '0;
      m_over  = 1'b0;
    end else begin
      full    = (q.size() == DEPTH);
      do_push = bus.write && bus.write_ce && !full;
      if (bus.write && bus.write_ce && full) m_over = 1'b1;
      acc      = '0;
      all_done = 1'b1;
      for (int k = 0; k < NR; k++) begin
        if (bus.read[k] && bus.read_ce) begin
          if (q.size() != 0 && !m_taken[k]) acc[k] = 1'b1;
          else m_under[k] = 1'b1;
        end
        if (!(m_taken[k] || acc[k])) all_done = 1'b0;
      end
      if (all_done && q.size() != 0) begin
        void'(q.pop_front());
        m_taken = '0;
      end else begin
        m_taken = m_taken | acc;
      end
      if (do_push) q.push_back(bus.din);
    end
  endtask

  task automatic check_all(input string tag);
    int            n;
    logic [NR-1:0] exp_e;
    n = q.size();
    for (int k = 0; k < NR; k++) exp_e[k] = (n != 0) && !m_taken[k];
    check({tag, ".usedw"}, 32'(usedw), 32'(n));
    check({tag, ".full_n"}, 32'(bus.full_n), 32'(n != DEPTH));
    check({tag, ".empty_n"}, 32'(bus.empty_n), 32'(exp_e));
    if (n != 0) check({tag, ".dout"}, 32'(bus.dout), 32'(q[0]));
    check({tag, ".af"}, 32'(almost_full), 32'(n >= AF));
    check({tag, ".ae"}, 32'(almost_empty), 32'(n <= AE));
    check({tag, ".ovf"}, 32'(wr_overflow), 32'(m_over));
    check({tag, ".udf"}, 32'(rd_underflow), 32'(m_under));
  endtask

  task automatic tick(input string tag);
    model_step();
    @(posedge clk);
    #1;
    check_all(tag);
  endtask

  initial begin
    drive(1'b1, 1'b0, 1'b0, '0, 1'b0, '0);
    tick("rst0");
    tick("rst1");
    check("rst.empty_n", 32'(bus.empty_n), 32'h0);
    check("rst.ae", 32'(almost_empty), 32'h1);

    // T1: single write becomes visible to both consumers one cycle later
    drive(1'b0, 1'b1, 1'b1, 4'hA, 1'b1, 2'b00);
    tick("t1");
    check("t1.empty_n", 32'(bus.empty_n), 32'h3);
    check("t1.dout", 32'(bus.dout), 32'hA);

    // T2: consumers read the head one after another
    drive(1'b0, 1'b0, 1'b1, 4'h0, 1'b1, 2'b01);
    tick("t2a");
    check("t2a.empty_n", 32'(bus.empty_n), 32'h2);
    check("t2a.usedw", 32'(usedw), 32'h1);
    drive(1'b0, 1'b0, 1'b1, 4'h0, 1'b1, 2'b10);
    tick("t2b");
    check("t2b.usedw", 32'(usedw), 32'h0);

    // T3: fill to full, then one refused write
    for (int i = 1; i <= 4; i++) begin
      drive(1'b0, 1'b1, 1'b1, DW'(i), 1'b1, 2'b00);
      tick("t3");
      if (i == 3) check("t3.af_at3", 32'(almost_full), 32'h1);
    end
    check("t3.full_n", 32'(bus.full_n), 32'h0);
    drive(1'b0, 1'b1, 1'b1, 4'h5, 1'b1, 2'b00);
    tick("t3ovf");
    check("t3.ovf", 32'(wr_overflow), 32'h1);

    // T4: full, pop and write in the same cycle -> write still refused
    drive(1'b0, 1'b1, 1'b1, 4'h6, 1'b1, 2'b11);
    tick("t4");
    check("t4.usedw", 32'(usedw), 32'h3);
    check("t4.dout", 32'(bus.dout), 32'h2);

    // T5: simultaneous push and pop keep the count
    drive(1'b0, 1'b0, 1'b1, 4'h0, 1'b1, 2'b11);
    tick("t5a");
    drive(1'b0, 1'b1, 1'b1, 4'h7, 1'b1, 2'b11);
    tick("t5b");
    check("t5.usedw", 32'(usedw), 32'h2);
    check("t5.dout", 32'(bus.dout), 32'h4);

    // T6: second read by the same consumer underflows, then reset clears everything
    drive(1'b0, 1'b0, 1'b1, 4'h0, 1'b1, 2'b10);
    tick("t6a");
    check("t6a.empty_n", 32'(bus.empty_n), 32'h1);
    drive(1'b0, 1'b0, 1'b1, 4'h0, 1'b1, 2'b10);
    tick("t6b");
    check("t6b.udf", 32'(rd_underflow), 32'h2);
    drive(1'b1, 1'b1, 1'b1, 4'h9, 1'b1, 2'b11);
    tick("t6rst");
    check("t6rst.udf", 32'(rd_underflow), 32'h0);
    check("t6rst.ovf", 32'(wr_overflow), 32'h0);

    // Random traffic with occasional resets
    for (int c = 0; c < 500; c++) begin
      drive(($urandom_range(0, 59) == 0), 1'($urandom), ($urandom_range(0, 7) != 0),
            DW'($urandom), ($urandom_range(0, 7) != 0), NR'($urandom));
      tick("rnd");
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
